alu_issue_ctrl: RTL

- Requester-side controller for the ALU.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU command and operand inputs.
- Captures the combinational result and, for compare ops, the flags the ALU registers on the following clock edge.
- Returns result, flags and tag over a valid/ready response channel.
- Sits between decode/issue and the ALU; it is the only driver of the ALU command and operand inputs.

---
 rtl/alu_issue_ctrl_if.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: groups the request channel, the ALU drive/return bus and
// the response channel of the ALU issue controller.
//   req_*  : valid/ready request (opcode, operands, tag)
//   alu_*  : command/operands to the ALU, result and registered flags back
//   rsp_*  : valid/ready response (result, flags, error, tag)
// Modport slave is the controller side; master is the requester/consumer/ALU side.
interface alu_issue_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 5,
  parameter int TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [WORD_W-1:0] req_a;
  logic [WORD_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic [OP_W-1:0]   alu_com;
  logic [WORD_W-1:0] alu_in0;
  logic [WORD_W-1:0] alu_in1;
  logic [WORD_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_sign;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_result;
  logic              rsp_c;
  logic              rsp_s;
  logic              rsp_z;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    input  alu_out, alu_carry, alu_sign, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_com, alu_in0, alu_in1,
    output rsp_valid, rsp_result, rsp_c, rsp_s, rsp_z, rsp_err, rsp_tag
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    output alu_out, alu_carry, alu_sign, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_com, alu_in0, alu_in1,
    input  rsp_valid, rsp_result, rsp_c, rsp_s, rsp_z, rsp_err, rsp_tag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side controller for the ALU. Accepts one operation
// at a time, drives the ALU from held registers, captures the combinational
// result (and for compares the flags the ALU registers one edge later) and
// returns result/flags/error/tag on a valid/ready response channel.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; abandons any operation in flight
//   bus  - alu_issue_ctrl_if.slave (request, ALU drive/return, response)
module alu_issue_ctrl #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 5,
  parameter int TAG_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [OP_W-1:0] ALU_OP_THA_WORD = 5'd0;
  localparam logic [OP_W-1:0] ALU_OP_DIV      = 5'd9;
  localparam logic [OP_W-1:0] ALU_OP_MOD      = 5'd10;
  localparam logic [OP_W-1:0] ALU_OP_CMP      = 5'd11;
  localparam logic [OP_W-1:0] ALU_OP_CGE      = 5'd12;
  localparam logic [OP_W-1:0] ALU_OP_CGT      = 5'd13;
  localparam logic [OP_W-1:0] ALU_OP_SHR      = 5'd19;

  typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

  // Legal codes are contiguous from THA_WORD up to SHR.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= ALU_OP_SHR);
  endfunction

  function automatic logic op_is_cmp(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      ALU_OP_CMP, ALU_OP_CGE, ALU_OP_CGT: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_divmod(input logic [OP_W-1:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
  endfunction

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              c_q, c_d;
  logic              s_q, s_d;
  logic              z_q, z_d;
  logic              err_q, err_d;

  // Next-state and capture logic for the issue sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    result_d = result_q;
    c_d      = c_q;
    s_d      = s_q;
    z_d      = z_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          tag_d = bus.req_tag;
          if (!op_is_legal(bus.req_op) ||
              (op_is_divmod(bus.req_op) && (bus.req_b == {WORD_W{1'b0}}))) begin
            // Rejected ops never reach the ALU; the held op stays THA_WORD.
            state_d  = RESP;
            err_d    = 1'b1;
            result_d = {WORD_W{1'b0}};
            c_d      = bus.alu_carry;
            s_d      = bus.alu_sign;
            z_d      = bus.alu_zero;
          end else begin
            state_d = EXEC;
            op_d    = bus.req_op;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        // The compare is driven during this cycle, so the ALU flags update
        // on this edge; afterwards the ALU idles on THA_WORD.
        op_d     = ALU_OP_THA_WORD;
        if (op_is_cmp(op_q)) begin
          state_d = FLAG;
        end else begin
          c_d     = bus.alu_carry;
          s_d     = bus.alu_sign;
          z_d     = bus.alu_zero;
          state_d = RESP;
        end
      end
      FLAG: begin
        op_d    = ALU_OP_THA_WORD;
        c_d     = bus.alu_carry;
        s_d     = bus.alu_sign;
        z_d     = bus.alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = ALU_OP_THA_WORD;
      end
    endcase
  end

  // State and held/captured registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= ALU_OP_THA_WORD;
      a_q      <= {WORD_W{1'b0}};
      b_q      <= {WORD_W{1'b0}};
      tag_q    <= {TAG_W{1'b0}};
      result_q <= {WORD_W{1'b0}};
      c_q      <= 1'b0;
      s_q      <= 1'b0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      c_q      <= c_d;
      s_q      <= s_d;
      z_q      <= z_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.alu_com    = op_q;
  assign bus.alu_in0    = a_q;
  assign bus.alu_in1    = b_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_err    = err_q;
  assign bus.rsp_tag    = tag_q;

endmodule
